// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector for raster-order multi-channel video.
// Builds the window from two internal line buffers. Results appear 3 cycles
// after the pixel is sampled, centred one row and one column behind it.
module sobel_stream #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned MODE     = 0,
    localparam int unsigned LW      = PIX_W + $clog2(CHANNELS + 1),
    localparam int unsigned GW      = LW + 4,
    localparam int unsigned MAG_W   = (MODE != 0) ? (2 * GW - 1) : GW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [PIX_W*CHANNELS-1:0] in_pixel,
    input  logic [MAG_W-1:0]          threshold,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic [MAG_W-1:0]          out_mag,
    output logic                      out_edge
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = 16;

    // position counters and the position of the incoming pixel
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    logic [LW-1:0] luma_c;

    // input register stage
    logic          s0_valid;
    logic          s0_sof;
    logic          s0_border;
    logic [CW-1:0] s0_col;
    logic [LW-1:0] s0_luma;

    // line buffers: lb0 holds the previous line, lb1 the line before it
    logic [LW-1:0] lb0 [IMG_W];
    logic [LW-1:0] lb1 [IMG_W];

    // window stage
    logic          s1_valid;
    logic          s1_sof;
    logic          s1_border;
    logic [LW-1:0] win [3][3];

    // gradient stage
    logic                 s2_valid;
    logic                 s2_sof;
    logic                 s2_border;
    logic signed [GW-1:0] s2_gx;
    logic signed [GW-1:0] s2_gy;
    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;

    // magnitude stage combinational terms
    logic [GW-1:0]    ax_c;
    logic [GW-1:0]    ay_c;
    logic [GW:0]      sum_c;
    logic [2*GW-1:0]  sq_c;
    logic [MAG_W-1:0] mag_c;

    function automatic logic signed [GW-1:0] sx(input logic [LW-1:0] v);
        return $signed(GW'(v));
    endfunction

    // sof forces the pixel to (0,0); luma is the plain channel sum
    always_comb begin
        pix_col = in_sof ? '0 : col_cnt;
        pix_row = in_sof ? '0 : row_cnt;
        luma_c  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            luma_c = luma_c + LW'(in_pixel[k*PIX_W +: PIX_W]);
        end
    end

    // raster position: column wraps into the next row, row saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (in_valid) begin
            if (pix_col == CW'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (pix_row == '1) ? pix_row : pix_row + RW'(1);
            end else begin
                col_cnt <= pix_col + CW'(1);
                row_cnt <= pix_row;
            end
        end
    end

    // register the pixel luma, its column and whether its window is incomplete
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid  <= 1'b0;
            s0_sof    <= 1'b0;
            s0_border <= 1'b0;
            s0_col    <= '0;
            s0_luma   <= '0;
        end else begin
            s0_valid <= in_valid;
            s0_sof   <= in_valid & in_sof;
            if (in_valid) begin
                s0_border <= (pix_row < RW'(2)) || (pix_col < CW'(2));
                s0_col    <= pix_col;
                s0_luma   <= luma_c;
            end
        end
    end

    // line buffers shift one line down at the current column (contents never reset)
    always_ff @(posedge clk) begin
        if (s0_valid) begin
            lb0[s0_col] <= s0_luma;
            lb1[s0_col] <= lb0[s0_col];
        end
    end

    // shift the window left and insert the new column, oldest line on top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_border <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            s1_valid <= s0_valid;
            s1_sof   <= s0_sof;
            if (s0_valid) begin
                s1_border <= s0_border;
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb1[s0_col];
                win[1][2] <= lb0[s0_col];
                win[2][2] <= s0_luma;
            end
        end
    end

    // Sobel kernels at full signed width
    always_comb begin
        gx_c = sx(win[0][0]) - sx(win[0][2])
             + (sx(win[1][0]) <<< 1) - (sx(win[1][2]) <<< 1)
             + sx(win[2][0]) - sx(win[2][2]);
        gy_c = sx(win[2][0]) + (sx(win[2][1]) <<< 1) + sx(win[2][2])
             - sx(win[0][0]) - (sx(win[0][1]) <<< 1) - sx(win[0][2]);
    end

    // register gradients
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_border <= 1'b0;
            s2_gx     <= '0;
            s2_gy     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            if (s1_valid) begin
                s2_border <= s1_border;
                s2_gx     <= gx_c;
                s2_gy     <= gy_c;
            end
        end
    end

    // magnitude: L1 norm or squared L2 norm, never truncated for reachable inputs
    always_comb begin
        ax_c  = s2_gx[GW-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
        ay_c  = s2_gy[GW-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
        sum_c = (GW+1)'(ax_c) + (GW+1)'(ay_c);
        sq_c  = (2*GW)'(ax_c) * (2*GW)'(ax_c) + (2*GW)'(ay_c) * (2*GW)'(ay_c);
        mag_c = (MODE != 0) ? MAG_W'(sq_c) : MAG_W'(sum_c);
    end

    // output register: border results masked, idle cycles drive zeros
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_mag   <= '0;
            out_edge  <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid && !s2_border) begin
                out_sof  <= s2_sof;
                out_mag  <= mag_c;
                out_edge <= (mag_c > threshold);
            end else begin
                out_sof  <= s2_valid & s2_sof;
                out_mag  <= '0;
                out_edge <= 1'b0;
            end
        end
    end

endmodule
